// File: rtl/axi_sb_pkg.sv
// axi_sb_pkg: shared types and field positions for the AXI sideband attribute controller
package axi_sb_pkg;
  typedef enum logic [2:0] {
    OP_NOP, OP_WR_AW, OP_WR_AR, OP_RD_AW, OP_RD_AR, OP_DEFAULTS, OP_ILL6, OP_ILL7
  } op_e;
  typedef enum logic [1:0] {RES_OK, RES_BAD_OP, RES_TIMEOUT} res_e;
  typedef enum logic [2:0] {
    S_SYNC, S_IDLE, S_CHECK, S_BLOCK, S_DRAIN, S_APPLY, S_RESPOND
  } state_e;
  typedef struct packed {
    logic [4:0] user;
    logic [2:0] prot;
    logic [3:0] cache;
  } attr_t;
  localparam int CMD_REQ = 31;
  localparam int CMD_OP_LO = 28;
  localparam int ST_ACK = 31;
  localparam int ST_OP_LO = 28;
  localparam int ST_RES_LO = 26;
  localparam int ST_BUSY = 25;
  localparam int ST_ERR = 24;
  localparam int ST_STATE_LO = 12;
  localparam int DEF_MAX_OUT = 15;
  localparam int CNT_W = $clog2(DEF_MAX_OUT + 1);
endpackage

// File: rtl/axi_outstanding_cnt.sv
// axi_outstanding_cnt: saturating outstanding-transaction counter with sticky over/underflow flag
module axi_outstanding_cnt
  import axi_sb_pkg::*;
#(
  parameter int MAX_OUT = DEF_MAX_OUT,
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         err_o
);
  logic [W-1:0] count_q, count_d;
  logic err_q, err_d, up, dn, ovf, unf;
  always_comb begin
    up = inc_i && !dec_i;
    dn = dec_i && !inc_i;
    ovf = up && count_q == W'(MAX_OUT);
    unf = dn && count_q == '0;
    count_d = (up && !ovf) ? count_q + 1'b1 : (dn && !unf) ? count_q - 1'b1 : count_q;
    err_d = err_q | ovf | unf;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q <= err_d;
    end
  end
  assign count_o = count_q;
  assign err_o = err_q;
endmodule

// File: rtl/axi_sideband_ctrl.sv
// axi_sideband_ctrl: PIO-driven runtime control of AxCACHE/AxPROT/AxUSER,
// changing a channel's attributes only after blocking and draining it.
module axi_sideband_ctrl
  import axi_sb_pkg::*;
#(
  parameter int         MAX_OUT       = 15,
  parameter int         DRAIN_TIMEOUT = 1024,
  parameter logic [3:0] DEF_CACHE     = 4'b1111,
  parameter logic [2:0] DEF_PROT      = 3'b000,
  parameter logic [4:0] DEF_USER      = 5'b00001
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] cmd_word,
  output logic [31:0] status_word,
  output logic [3:0]  axi_signals_awcache,
  output logic [2:0]  axi_signals_awprot,
  output logic [4:0]  axi_signals_awuser,
  output logic [3:0]  axi_signals_arcache,
  output logic [2:0]  axi_signals_arprot,
  output logic [4:0]  axi_signals_aruser,
  output logic        aw_block,
  output logic        ar_block,
  input  logic        awvalid,
  input  logic        awready,
  input  logic        bvalid,
  input  logic        bready,
  input  logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic        rready,
  input  logic        rlast
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam attr_t DEF_ATTR = '{user: DEF_USER, prot: DEF_PROT, cache: DEF_CACHE};
  state_e state_q;
  op_e op_q, st_op_q;
  res_e res_q, st_res_q;
  attr_t pay_q, rd_q, st_pay_q, aw_q, ar_q;
  logic ack_q, busy_q, werr, rerr, drained, unused;
  logic [TW-1:0] tmr_q;
  logic [CW-1:0] wcnt, rcnt;
  axi_outstanding_cnt #(.MAX_OUT(MAX_OUT), .W(CW)) u_wcnt (
    .clk_i(clk_clk), .rst_i(reset_reset), .inc_i(awvalid && awready),
    .dec_i(bvalid && bready), .count_o(wcnt), .err_o(werr)
  );
  axi_outstanding_cnt #(.MAX_OUT(MAX_OUT), .W(CW)) u_rcnt (
    .clk_i(clk_clk), .rst_i(reset_reset), .inc_i(arvalid && arready),
    .dec_i(rvalid && rready && rlast), .count_o(rcnt), .err_o(rerr)
  );
  assign drained = (!aw_block || (wcnt == '0 && !awvalid)) && (!ar_block || (rcnt == '0 && !arvalid));
  assign unused = ^cmd_word[27:12];
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= S_SYNC;
      op_q <= OP_NOP;
      res_q <= RES_OK;
      pay_q <= '0;
      rd_q <= '0;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
      tmr_q <= '0;
      aw_q <= DEF_ATTR;
      ar_q <= DEF_ATTR;
      aw_block <= 1'b0;
      ar_block <= 1'b0;
      st_op_q <= OP_NOP;
      st_res_q <= RES_OK;
      st_pay_q <= '0;
    end else begin
      case (state_q)
        // adopt whatever toggle is pending at reset so it is never executed
        S_SYNC: begin
          ack_q <= cmd_word[CMD_REQ];
          state_q <= S_IDLE;
        end
        S_IDLE: if (cmd_word[CMD_REQ] != ack_q) begin
          op_q <= op_e'(cmd_word[CMD_OP_LO +: 3]);
          pay_q <= attr_t'(cmd_word[11:0]);
          busy_q <= 1'b1;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          aw_block <= op_q inside {OP_WR_AW, OP_DEFAULTS};
          ar_block <= op_q inside {OP_WR_AR, OP_DEFAULTS};
          rd_q <= op_q == OP_RD_AW ? aw_q : op_q == OP_RD_AR ? ar_q : '0;
          res_q <= op_q inside {OP_ILL6, OP_ILL7} ? RES_BAD_OP : RES_OK;
          state_q <= op_q inside {OP_WR_AW, OP_WR_AR, OP_DEFAULTS} ? S_BLOCK : S_RESPOND;
        end
        S_BLOCK: begin
          tmr_q <= '0;
          state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drained) begin
            state_q <= S_APPLY;
          end else if (tmr_q == TW'(DRAIN_TIMEOUT)) begin
            res_q <= RES_TIMEOUT;
            state_q <= S_RESPOND;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_APPLY: begin
          aw_q <= op_q == OP_DEFAULTS ? DEF_ATTR : op_q == OP_WR_AW ? pay_q : aw_q;
          ar_q <= op_q == OP_DEFAULTS ? DEF_ATTR : op_q == OP_WR_AR ? pay_q : ar_q;
          state_q <= S_RESPOND;
        end
        S_RESPOND: begin
          st_op_q <= op_q;
          st_res_q <= res_q;
          st_pay_q <= rd_q;
          ack_q <= ~ack_q;
          busy_q <= 1'b0;
          aw_block <= 1'b0;
          ar_block <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end
  always_comb begin
    status_word = '0;
    status_word[ST_ACK] = ack_q;
    status_word[ST_OP_LO +: 3] = st_op_q;
    status_word[ST_RES_LO +: 2] = st_res_q;
    status_word[ST_BUSY] = busy_q;
    status_word[ST_ERR] = werr | rerr;
    status_word[ST_STATE_LO +: 4] = {1'b0, state_q};
    status_word[11:0] = st_pay_q;
  end
  assign {axi_signals_awuser, axi_signals_awprot, axi_signals_awcache} = aw_q;
  assign {axi_signals_aruser, axi_signals_arprot, axi_signals_arcache} = ar_q;
endmodule

// File: tb/tb_axi_sideband_ctrl.sv
// tb_axi_sideband_ctrl: randomized scoreboard bench; expected status is queued at
// command issue and checked by an independent monitor on every ack toggle.
module tb_axi_sideband_ctrl;
  localparam int T = 16;
  localparam int MAXO = 15;
  localparam logic [11:0] DEF = {5'b00001, 3'b000, 4'b1111};
  localparam logic [8:0] AW = 9'h003, B = 9'h00C, AR = 9'h030, R = 9'h0C0, RL = 9'h1C0;
  logic clk = 1'b0, reset_reset;
  logic [31:0] cmd_word, status_word;
  logic [3:0] axi_signals_awcache, axi_signals_arcache;
  logic [2:0] axi_signals_awprot, axi_signals_arprot;
  logic [4:0] axi_signals_awuser, axi_signals_aruser;
  logic aw_block, ar_block;
  logic awvalid, awready, bvalid, bready, arvalid, arready, rvalid, rready, rlast;
  axi_sideband_ctrl #(.MAX_OUT(MAXO), .DRAIN_TIMEOUT(T), .DEF_CACHE(4'b1111),
                      .DEF_PROT(3'b000), .DEF_USER(5'b00001)) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .cmd_word(cmd_word), .status_word(status_word),
    .axi_signals_awcache(axi_signals_awcache), .axi_signals_awprot(axi_signals_awprot),
    .axi_signals_awuser(axi_signals_awuser), .axi_signals_arcache(axi_signals_arcache),
    .axi_signals_arprot(axi_signals_arprot), .axi_signals_aruser(axi_signals_aruser),
    .aw_block(aw_block), .ar_block(ar_block), .awvalid(awvalid), .awready(awready),
    .bvalid(bvalid), .bready(bready), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rlast(rlast)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  op;
    logic [1:0]  res;
    logic [11:0] pay;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, wc = 0, rc = 0;
  bit err_m = 0, req = 1, mon_en = 0, last_ack = 0;
  logic [11:0] aw_m = DEF, ar_m = DEF, old_aw;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, exp, cyc);
    end
  endtask
  // monitor: every ack toggle consumes one expected response
  always @(negedge clk) begin
    if (!mon_en) last_ack = status_word[31];
    else if (status_word[31] !== last_ack) begin
      last_ack = status_word[31];
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack toggled to %0b with nothing pending", last_ack);
      end else begin
        e = q.pop_front();
        chk("status_op", 32'(status_word[30:28]), 32'(e.op));
        chk("status_result", 32'(status_word[27:26]), 32'(e.res));
        chk("status_payload", 32'(status_word[11:0]), 32'(e.pay));
        chk("status_err", 32'(status_word[24]), 32'(err_m));
        chk("status_busy", 32'(status_word[25]), 0);
        chk("status_state_rsvd", 32'(status_word[23:12]), 32'h001);
        chk("blocks_after_respond", {aw_block, ar_block}, 0);
        chk("aw_attrs", {axi_signals_awuser, axi_signals_awprot, axi_signals_awcache}, aw_m);
        chk("ar_attrs", {axi_signals_aruser, axi_signals_arprot, axi_signals_arcache}, ar_m);
        if (e.due >= 0) chk("ack_latency", cyc, e.due);
      end
    end
  end
  task automatic bus(input logic [8:0] v);
    bit aw, b, ar, r;
    {rlast, rready, rvalid, arready, arvalid, bready, bvalid, awready, awvalid} = v;
    aw = v[0] & v[1];
    b = v[2] & v[3];
    ar = v[4] & v[5];
    r = v[6] & v[7] & v[8];
    if (aw && !b) begin if (wc == MAXO) err_m = 1; else wc++; end
    else if (b && !aw) begin if (wc == 0) err_m = 1; else wc--; end
    if (ar && !r) begin if (rc == MAXO) err_m = 1; else rc++; end
    else if (r && !ar) begin if (rc == 0) err_m = 1; else rc--; end
    @(negedge clk);
    {rlast, rready, rvalid, arready, arvalid, bready, bvalid, awready, awvalid} = '0;
  endtask
  task automatic issue(input logic [2:0] op, input logic [11:0] pay, input bit tmo, input bit lat_chk);
    exp_t x;
    bit wr;
    wr = op == 1 || op == 2 || op == 5;
    x.op = op;
    x.res = op > 5 ? 2'd1 : tmo ? 2'd2 : 2'd0;
    x.pay = op == 3 ? aw_m : op == 4 ? ar_m : 12'h0;
    if (!tmo && (op == 1 || op == 5)) aw_m = op == 5 ? DEF : pay;
    if (!tmo && (op == 2 || op == 5)) ar_m = op == 5 ? DEF : pay;
    x.due = !lat_chk ? -1 : cyc + 1 + (tmo ? T + 4 : wr ? 5 : 2);
    q.push_back(x);
    req = ~req;
    cmd_word = {req, op, 16'($urandom), pay};
  endtask
  task automatic wait_ack();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: %0d responses still pending after %0d cycles", q.size(), n);
      q.delete();
    end
  endtask
  task automatic do_reset();
    mon_en = 0;
    reset_reset = 1;
    @(negedge clk);
    chk("reset_status", status_word, 0);
    chk("reset_blocks", {aw_block, ar_block}, 0);
    chk("reset_aw", {axi_signals_awuser, axi_signals_awprot, axi_signals_awcache}, DEF);
    chk("reset_ar", {axi_signals_aruser, axi_signals_arprot, axi_signals_arcache}, DEF);
    reset_reset = 0;
    q.delete();
    aw_m = DEF;
    ar_m = DEF;
    wc = 0;
    rc = 0;
    err_m = 0;
    @(negedge clk);
    chk("sync_ack", 32'(status_word[31]), 32'(req));
    chk("sync_state", 32'(status_word[15:12]), 1);
    @(negedge clk);
    mon_en = 1;
  endtask
  initial begin
    {rlast, rready, rvalid, arready, arvalid, bready, bvalid, awready, awvalid} = '0;
    cmd_word = {1'b1, 3'd1, 16'h0, 12'h123};
    do_reset();
    repeat (6) @(negedge clk);
    chk("stale_not_run_busy", 32'(status_word[25]), 0);
    chk("stale_not_run_aw", {axi_signals_awuser, axi_signals_awprot, axi_signals_awcache}, DEF);
    // directed write with exact edge timing
    issue(3'd1, 12'h8A3, 0, 1);
    @(negedge clk);
    chk("busy_set", 32'(status_word[25]), 1);
    chk("aw_block_in_check", 32'(aw_block), 0);
    @(negedge clk);
    chk("aw_block_raised", {aw_block, ar_block}, 2'b10);
    repeat (2) @(negedge clk);
    chk("aw_before_apply", {axi_signals_awuser, axi_signals_awprot, axi_signals_awcache}, DEF);
    @(negedge clk);
    chk("awuser_applied", 32'(axi_signals_awuser), 32'h11);
    chk("awprot_applied", 32'(axi_signals_awprot), 32'h2);
    chk("awcache_applied", 32'(axi_signals_awcache), 32'h3);
    wait_ack();
    // read-side write proceeds with writes outstanding; write-side waits for them
    repeat (3) bus(AW);
    issue(3'd2, 12'h0F0, 0, 1);
    wait_ack();
    old_aw = aw_m;
    issue(3'd1, 12'($urandom), 0, 0);
    @(negedge clk);
    cmd_word = {req, 31'($urandom)};
    repeat (8) @(negedge clk);
    chk("aw_block_while_draining", 32'(aw_block), 1);
    chk("aw_held_while_draining", {axi_signals_awuser, axi_signals_awprot, axi_signals_awcache}, old_aw);
    bus(B);
    bus(B);
    chk("aw_held_one_left", {axi_signals_awuser, axi_signals_awprot, axi_signals_awcache}, old_aw);
    bus(B);
    if (q.size() > 0) q[0].due = cyc + 3;
    wait_ack();
    // drain timeout on each channel (read one uses an R beat without rlast)
    bus(AW);
    issue(3'd1, 12'($urandom), 1, 1);
    wait_ack();
    bus(B);
    bus(AR);
    bus(R);
    issue(3'd2, 12'($urandom), 1, 1);
    wait_ack();
    bus(RL);
    issue(3'd7, 12'($urandom), 0, 1);
    wait_ack();
    issue(3'd6, 12'($urandom), 0, 1);
    wait_ack();
    issue(3'd5, 12'($urandom), 0, 1);
    wait_ack();
    issue(3'd4, 12'($urandom), 0, 1);
    wait_ack();
    chk("rd_ar_defaults", 32'(status_word[11:0]), 32'h08F);
    issue(3'd3, 12'($urandom), 0, 1);
    wait_ack();
    issue(3'd0, 12'($urandom), 0, 1);
    wait_ack();
    // simultaneous inc/dec, then underflow sets the sticky flag
    bus(AW | B);
    chk("simul_no_err", 32'(status_word[24]), 32'(err_m));
    issue(3'd1, 12'($urandom), 0, 1);
    wait_ack();
    bus(B);
    chk("underflow_err", 32'(status_word[24]), 32'(err_m));
    for (int i = 0; i < 30; i++) begin
      int n;
      n = $urandom_range(0, 8);
      repeat (n) bus(9'($urandom));
      while (wc > 0) bus(B);
      while (rc > 0) bus(RL);
      issue(3'($urandom), 12'($urandom), 0, 1);
      wait_ack();
    end
    // reset in the middle of a drain
    bus(AW);
    issue(3'd1, 12'($urandom), 0, 0);
    repeat (5) @(negedge clk);
    do_reset();
    repeat (MAXO) bus(AW);
    chk("full_no_err", 32'(status_word[24]), 32'(err_m));
    bus(AW);
    chk("saturate_err", 32'(status_word[24]), 32'(err_m));
    repeat (MAXO) bus(B);
    issue(3'd1, 12'($urandom), 0, 1);
    wait_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
